// File: rtl/verificador_senha.sv
// Sequential PIN checker: takes one digit per strobe, issues one acerto/erro verdict
// per completed entry and locks entry for a fixed time after too many consecutive errors.
module verificador_senha #(
    parameter int DIGIT_W     = 4,
    parameter int N_DIGITS    = 4,
    parameter int MAX_ERRORS  = 3,
    parameter int LOCK_CYCLES = 50000000
) (
    input  logic                                               clk,
    input  logic                                               reset,
    input  logic [DIGIT_W-1:0]                                 digito_in,
    input  logic                                               digito_valid,
    input  logic                                               limpar,
    input  logic [N_DIGITS*DIGIT_W-1:0]                        senha,
    output logic [1:0]                                         resultado,
    output logic                                               resultado_valid,
    output logic                                               bloqueado,
    output logic [((N_DIGITS > 1) ? $clog2(N_DIGITS) : 1)-1:0] indice,
    output logic [$clog2(MAX_ERRORS+1)-1:0]                    erros
);

    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int ERR_W = $clog2(MAX_ERRORS + 1);
    localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_DIGITS - 1);
    localparam logic [ERR_W-1:0] LAST_ERR  = ERR_W'(MAX_ERRORS - 1);
    localparam logic [ERR_W-1:0] MAX_ERR   = ERR_W'(MAX_ERRORS);
    localparam logic [CNT_W-1:0] LOCK_LOAD = CNT_W'(LOCK_CYCLES - 1);

    localparam logic [1:0] RES_ACERTO    = 2'b00;
    localparam logic [1:0] RES_ERRO      = 2'b01;
    localparam logic [1:0] RES_BLOQUEADO = 2'b10;
    localparam logic [1:0] RES_NENHUM    = 2'b11;

    typedef enum logic [1:0] {
        ENTRADA,
        VERIFICA,
        BLOQUEIO
    } estado_t;

    estado_t          r_estado;
    logic [IDX_W-1:0] r_indice;
    logic [ERR_W-1:0] r_erros;
    logic [CNT_W-1:0] r_contador;
    logic             r_erroFlag;
    logic [1:0]       r_resultado;
    logic             r_valid;
    logic             r_bloqueado;

    logic [DIGIT_W-1:0] w_digitoEsperado;
    logic               w_digitoErrado;

    // senha is read live; the user holds it stable for the whole entry
    assign w_digitoEsperado = senha[r_indice*DIGIT_W +: DIGIT_W];
    assign w_digitoErrado   = (digito_in != w_digitoEsperado);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_estado    <= ENTRADA;
            r_indice    <= '0;
            r_erros     <= '0;
            r_contador  <= '0;
            r_erroFlag  <= 1'b0;
            r_resultado <= RES_NENHUM;
            r_valid     <= 1'b0;
            r_bloqueado <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_estado)
                ENTRADA: begin
                    if (limpar) begin
                        r_indice   <= '0;
                        r_erroFlag <= 1'b0;
                    end else if (digito_valid) begin
                        r_erroFlag <= r_erroFlag | w_digitoErrado;
                        if (r_indice == LAST_IDX) begin
                            r_indice <= '0;
                            r_estado <= VERIFICA;
                        end else begin
                            r_indice <= r_indice + 1'b1;
                        end
                    end
                end
                VERIFICA: begin
                    r_erroFlag <= 1'b0;
                    r_valid    <= 1'b1;
                    if (!r_erroFlag) begin
                        r_resultado <= RES_ACERTO;
                        r_erros     <= '0;
                        r_estado    <= ENTRADA;
                    end else if (r_erros == LAST_ERR) begin
                        r_resultado <= RES_BLOQUEADO;
                        r_erros     <= MAX_ERR;
                        r_bloqueado <= 1'b1;
                        r_contador  <= LOCK_LOAD;
                        r_estado    <= BLOQUEIO;
                    end else begin
                        r_resultado <= RES_ERRO;
                        r_erros     <= r_erros + 1'b1;
                        r_estado    <= ENTRADA;
                    end
                end
                BLOQUEIO: begin
                    // counter runs LOCK_CYCLES-1 down to 0, so bloqueado stays high LOCK_CYCLES cycles
                    if (r_contador == '0) begin
                        r_bloqueado <= 1'b0;
                        r_erros     <= '0;
                        r_estado    <= ENTRADA;
                    end else begin
                        r_contador <= r_contador - 1'b1;
                    end
                end
                default: begin
                    r_estado <= ENTRADA;
                end
            endcase
        end
    end

    assign resultado       = r_resultado;
    assign resultado_valid = r_valid;
    assign bloqueado       = r_bloqueado;
    assign indice          = r_indice;
    assign erros           = r_erros;

endmodule

// File: tb/tb_verificador_senha.sv
// Directed self-checking bench for verificador_senha: verdicts, lockout, limpar,
// mid-operation reset and back-to-back digit strobes.
module tb_verificador_senha;

    localparam int DIGIT_W     = 4;
    localparam int N_DIGITS    = 4;
    localparam int MAX_ERRORS  = 3;
    localparam int LOCK_CYCLES = 8;

    logic                          clk;
    logic                          reset;
    logic [DIGIT_W-1:0]            digito_in;
    logic                          digito_valid;
    logic                          limpar;
    logic [N_DIGITS*DIGIT_W-1:0]   senha;
    logic [1:0]                    resultado;
    logic                          resultado_valid;
    logic                          bloqueado;
    logic [1:0]                    indice;
    logic [1:0]                    erros;

    int nCompared   = 0;
    int nMismatched = 0;
    int pulseCount  = 0;

    verificador_senha #(
        .DIGIT_W    (DIGIT_W),
        .N_DIGITS   (N_DIGITS),
        .MAX_ERRORS (MAX_ERRORS),
        .LOCK_CYCLES(LOCK_CYCLES)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .digito_in      (digito_in),
        .digito_valid   (digito_valid),
        .limpar         (limpar),
        .senha          (senha),
        .resultado      (resultado),
        .resultado_valid(resultado_valid),
        .bloqueado      (bloqueado),
        .indice         (indice),
        .erros          (erros)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // counts every resultado_valid pulse, sampled at the edge after it was raised
    always @(posedge clk) begin
        if (resultado_valid) pulseCount <= pulseCount + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nCompared++;
        if (observed !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // drive one digit (optionally with limpar) across the next rising edge
    task automatic applyStimulus(input logic [DIGIT_W-1:0] d, input logic lim);
        digito_in    = d;
        digito_valid = 1'b1;
        limpar       = lim;
        @(negedge clk);
        digito_valid = 1'b0;
        limpar       = 1'b0;
    endtask

    task automatic enterPin(input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] d2, input logic [3:0] d3);
        applyStimulus(d0, 1'b0);
        applyStimulus(d1, 1'b0);
        applyStimulus(d2, 1'b0);
        applyStimulus(d3, 1'b0);
    endtask

    // called at the negedge right after the last digit's edge
    task automatic expectVerdict(input string tag, input logic [1:0] res, input logic [1:0] err, input logic blq);
        checkOutput({tag, " no early pulse"}, resultado_valid, 1'b0);
        @(negedge clk);
        checkOutput({tag, " valid"}, resultado_valid, 1'b1);
        checkOutput({tag, " resultado"}, resultado, res);
        checkOutput({tag, " erros"}, erros, err);
        checkOutput({tag, " bloqueado"}, bloqueado, blq);
        checkOutput({tag, " indice"}, indice, 2'd0);
    endtask

    task automatic pulseReset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int cnt;
        int pulsesBefore;
        reset        = 1'b1;
        digito_in    = '0;
        digito_valid = 1'b0;
        limpar       = 1'b0;
        senha        = 16'h4321;
        repeat (2) @(negedge clk);
        checkOutput("rst resultado", resultado, 2'b11);
        checkOutput("rst valid", resultado_valid, 1'b0);
        checkOutput("rst bloqueado", bloqueado, 1'b0);
        checkOutput("rst indice", indice, 2'd0);
        checkOutput("rst erros", erros, 2'd0);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] correct PIN, spaced strobes");
        applyStimulus(4'd1, 1'b0); @(negedge clk);
        applyStimulus(4'd2, 1'b0); @(negedge clk);
        applyStimulus(4'd3, 1'b0);
        checkOutput("spaced indice3", indice, 2'd3);
        @(negedge clk);
        applyStimulus(4'd4, 1'b0);
        expectVerdict("ok1", 2'b00, 2'd0, 1'b0);
        @(negedge clk);
        checkOutput("ok1 pulse width", resultado_valid, 1'b0);
        checkOutput("ok1 hold", resultado, 2'b00);

        $display("[TB] single wrong digit then correct");
        enterPin(4'd1, 4'd2, 4'd9, 4'd4);
        expectVerdict("err1", 2'b01, 2'd1, 1'b0);
        @(negedge clk);
        enterPin(4'd1, 4'd2, 4'd3, 4'd4);
        expectVerdict("ok2", 2'b00, 2'd0, 1'b0);
        @(negedge clk);

        $display("[TB] lockout");
        enterPin(4'd9, 4'd2, 4'd3, 4'd4);
        expectVerdict("lk e1", 2'b01, 2'd1, 1'b0);
        @(negedge clk);
        enterPin(4'd1, 4'd2, 4'd3, 4'd0);
        expectVerdict("lk e2", 2'b01, 2'd2, 1'b0);
        @(negedge clk);
        enterPin(4'd5, 4'd5, 4'd5, 4'd5);
        expectVerdict("lk e3", 2'b10, 2'd3, 1'b1);
        pulsesBefore = pulseCount;
        cnt = 0;
        for (int i = 0; i < 40 && bloqueado; i++) begin
            cnt++;
            digito_in    = 4'd1;
            digito_valid = 1'b1;
            @(negedge clk);
        end
        digito_valid = 1'b0;
        checkOutput("lk cycles", cnt, LOCK_CYCLES);
        checkOutput("lk indice", indice, 2'd0);
        checkOutput("lk erros after", erros, 2'd0);
        checkOutput("lk bloqueado after", bloqueado, 1'b0);
        checkOutput("lk resultado after", resultado, 2'b10);
        @(negedge clk);
        checkOutput("lk no exit pulse", pulseCount - pulsesBefore, 1);

        $display("[TB] limpar");
        enterPin(4'd0, 4'd0, 4'd0, 4'd0);
        expectVerdict("lp e1", 2'b01, 2'd1, 1'b0);
        @(negedge clk);
        pulsesBefore = pulseCount;
        applyStimulus(4'd9, 1'b0);
        applyStimulus(4'd9, 1'b0);
        checkOutput("lp indice2", indice, 2'd2);
        applyStimulus(4'd3, 1'b1);
        checkOutput("lp indice", indice, 2'd0);
        repeat (3) @(negedge clk);
        checkOutput("lp no pulse", pulseCount - pulsesBefore, 0);
        checkOutput("lp erros", erros, 2'd1);
        enterPin(4'd1, 4'd2, 4'd3, 4'd4);
        expectVerdict("lp ok", 2'b00, 2'd0, 1'b0);
        @(negedge clk);

        $display("[TB] reset mid-entry and during lockout");
        applyStimulus(4'd1, 1'b0);
        applyStimulus(4'd2, 1'b0);
        pulseReset();
        checkOutput("rm indice", indice, 2'd0);
        checkOutput("rm resultado", resultado, 2'b11);
        for (int k = 0; k < MAX_ERRORS; k++) begin
            enterPin(4'd7, 4'd7, 4'd7, 4'd7);
            @(negedge clk);
            @(negedge clk);
        end
        checkOutput("rl locked", bloqueado, 1'b1);
        pulseReset();
        checkOutput("rl bloqueado", bloqueado, 1'b0);
        checkOutput("rl erros", erros, 2'd0);
        enterPin(4'd1, 4'd2, 4'd3, 4'd4);
        expectVerdict("rl ok", 2'b00, 2'd0, 1'b0);
        @(negedge clk);

        $display("[TB] back-to-back strobes");
        enterPin(4'd1, 4'd2, 4'd3, 4'd4);
        checkOutput("bb no early pulse", resultado_valid, 1'b0);
        applyStimulus(4'd1, 1'b0);
        checkOutput("bb valid", resultado_valid, 1'b1);
        checkOutput("bb resultado", resultado, 2'b00);
        checkOutput("bb verifica ignores", indice, 2'd0);
        applyStimulus(4'd1, 1'b0);
        checkOutput("bb indice1", indice, 2'd1);
        checkOutput("bb valid low", resultado_valid, 1'b0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
